// File: rtl/keypad_emulator.sv
// 4x4 membrane keypad model: answers active-low row strobes with active-low
// column levels from a static force mask plus a bouncing press sequencer.
module keypad_emulator #(
  parameter int unsigned BOUNCE_LEN = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  input  logic [15:0] force_mask,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_key,
  input  logic [15:0] req_hold,
  output logic        busy,
  output logic        key_closed,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_BNC,
    S_HOLD,
    S_REL_BNC,
    S_DONE
  } state_t;

  localparam logic [15:0] BNC_LAST = (BOUNCE_LEN == 0) ? 16'd0 : 16'(BOUNCE_LEN - 1);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] bnc_q, bnc_d;
  logic [3:0]  key_q, key_d;
  logic        contact_d;
  logic [15:0] pressed;
  logic [3:0]  col_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    bnc_d   = bnc_q;
    key_d   = key_q;
    lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          key_d   = req_key;
          hold_d  = (req_hold == '0) ? 16'd1 : req_hold;
          bnc_d   = '0;
          state_d = (BOUNCE_LEN == 0) ? S_HOLD : S_PRESS_BNC;
        end
      end
      S_PRESS_BNC: begin
        if (bnc_q == BNC_LAST) begin
          bnc_d   = '0;
          state_d = S_HOLD;
        end else begin
          bnc_d = bnc_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (hold_q == 16'd1) begin
          state_d = (BOUNCE_LEN == 0) ? S_DONE : S_REL_BNC;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      S_REL_BNC: begin
        if (bnc_q == BNC_LAST) begin
          bnc_d   = '0;
          state_d = S_DONE;
        end else begin
          bnc_d = bnc_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Contact is registered from the next state and next LFSR value, so during
    // bounce key_closed always equals bit 0 of the LFSR currently held.
    case (state_d)
      S_PRESS_BNC, S_REL_BNC: contact_d = lfsr_d[0];
      S_HOLD:                 contact_d = 1'b1;
      default:                contact_d = 1'b0;
    endcase

    pressed = force_mask | (key_closed ? (16'd1 << key_q) : '0);
    for (int unsigned c = 0; c < 4; c++) begin
      col_d[c] = 1'b1;
      for (int unsigned r = 0; r < 4; r++) begin
        if (!row_in[r] && pressed[4*r+c]) col_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_SEED;
      hold_q     <= '0;
      bnc_q      <= '0;
      key_q      <= '0;
      col_out    <= '1;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      key_closed <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      hold_q     <= hold_d;
      bnc_q      <= bnc_d;
      key_q      <= key_d;
      col_out    <= col_d;
      req_ready  <= (state_d == S_IDLE);
      busy       <= (state_d != S_IDLE);
      key_closed <= contact_d;
      done       <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: one instance without bounce, one with 8-cycle bounce.
module tb_keypad_emulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in;
  logic [15:0] force_mask;
  logic        req_valid;
  logic [3:0]  req_key;
  logic [15:0] req_hold;

  logic [3:0] col0, col8;
  logic       rdy0, rdy8, busy0, busy8, kc0, kc8, done0, done8;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  row;
    logic [15:0] fm;
    logic [3:0]  col;
  } vec_t;

  typedef struct {
    logic       kc;
    logic [3:0] col;
    logic       done;
    logic       ready;
    logic       busy;
  } exp_t;

  vec_t       vecs[10];
  logic [3:0] colq[$];
  exp_t       sbq[$];
  logic [15:0] lfsr_m;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  keypad_emulator #(.BOUNCE_LEN(0), .LFSR_SEED(16'hACE1)) dut0 (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col0), .force_mask(force_mask),
    .req_valid(req_valid), .req_ready(rdy0), .req_key(req_key), .req_hold(req_hold),
    .busy(busy0), .key_closed(kc0), .done(done0)
  );

  keypad_emulator #(.BOUNCE_LEN(8), .LFSR_SEED(16'hACE1)) dut8 (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col8), .force_mask(force_mask),
    .req_valid(req_valid), .req_ready(rdy8), .req_key(req_key), .req_hold(req_hold),
    .busy(busy8), .key_closed(kc8), .done(done8)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [3:0] ec;

    vecs[0] = '{row: 4'b1110, fm: 16'h0020, col: 4'b1111};
    vecs[1] = '{row: 4'b1101, fm: 16'h0020, col: 4'b1101};
    vecs[2] = '{row: 4'b1011, fm: 16'h0020, col: 4'b1111};
    vecs[3] = '{row: 4'b0111, fm: 16'h0020, col: 4'b1111};
    vecs[4] = '{row: 4'b0000, fm: 16'h8001, col: 4'b0110};
    vecs[5] = '{row: 4'b1111, fm: 16'h8001, col: 4'b1111};
    vecs[6] = '{row: 4'b0111, fm: 16'hFFFF, col: 4'b0000};
    vecs[7] = '{row: 4'b0000, fm: 16'h0000, col: 4'b1111};
    vecs[8] = '{row: 4'b1010, fm: 16'h0421, col: 4'b1010};
    vecs[9] = '{row: 4'b1101, fm: 16'h0421, col: 4'b1101};

    rst        = 1'b1;
    row_in     = 4'b0000;
    force_mask = 16'hFFFF;
    req_valid  = 1'b0;
    req_key    = 4'h0;
    req_hold   = 16'd0;

    // Reset with every key forced and every row strobed
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_col0", 16'(col0), 16'hF);
      chk("rst_col8", 16'(col8), 16'hF);
      chk("rst_busy", 16'({busy0, busy8}), 16'h0);
      chk("rst_done", 16'({done0, done8}), 16'h0);
      chk("rst_ready", 16'({rdy0, rdy8}), 16'h0);
      chk("rst_kc", 16'({kc0, kc8}), 16'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_col", 16'(col0), 16'h0);
    chk("post_rst_ready", 16'(rdy0), 16'h1);
    chk("post_rst_busy", 16'(busy0), 16'h0);
    chk("post_rst_done", 16'(done0), 16'h0);

    // Static-mask vectors through the scoreboard
    for (int i = 0; i < 10; i++) begin
      row_in     = vecs[i].row;
      force_mask = vecs[i].fm;
      colq.push_back(vecs[i].col);
      @(negedge clk);
      ec = colq.pop_front();
      chk($sformatf("vec%0d_col0", i), 16'(col0), 16'(ec));
      chk($sformatf("vec%0d_col8", i), 16'(col8), 16'(ec));
    end

    // BOUNCE_LEN=0: press key A hold 3, second request held during busy
    force_mask = 16'h0000;
    row_in     = 4'b1011;
    req_valid  = 1'b1;
    req_key    = 4'hA;
    req_hold   = 16'd3;
    sbq.push_back('{1'b1, 4'b1111, 1'b0, 1'b0, 1'b1});
    sbq.push_back('{1'b1, 4'b1011, 1'b0, 1'b0, 1'b1});
    sbq.push_back('{1'b1, 4'b1011, 1'b0, 1'b0, 1'b1});
    sbq.push_back('{1'b0, 4'b1011, 1'b1, 1'b0, 1'b1});
    sbq.push_back('{1'b0, 4'b1111, 1'b0, 1'b1, 1'b0});
    sbq.push_back('{1'b1, 4'b1111, 1'b0, 1'b0, 1'b1});
    sbq.push_back('{1'b1, 4'b1101, 1'b0, 1'b0, 1'b1});
    sbq.push_back('{1'b0, 4'b1101, 1'b1, 1'b0, 1'b1});
    sbq.push_back('{1'b0, 4'b1111, 1'b0, 1'b1, 1'b0});
    sbq.push_back('{1'b0, 4'b1111, 1'b0, 1'b1, 1'b0});
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("seq0_k%0d_kc", k), 16'(kc0), 16'(e.kc));
      chk($sformatf("seq0_k%0d_col", k), 16'(col0), 16'(e.col));
      chk($sformatf("seq0_k%0d_done", k), 16'(done0), 16'(e.done));
      chk($sformatf("seq0_k%0d_ready", k), 16'(rdy0), 16'(e.ready));
      chk($sformatf("seq0_k%0d_busy", k), 16'(busy0), 16'(e.busy));
      if (k == 1) begin
        req_key  = 4'h5;
        req_hold = 16'd2;
        row_in   = 4'b1001;
      end
      if (k == 6) req_valid = 1'b0;
    end

    // BOUNCE_LEN=8, hold 0 treated as 1: contact follows the reference LFSR
    do_reset();
    row_in    = 4'b1111;
    req_valid = 1'b1;
    req_key   = 4'h3;
    req_hold  = 16'd0;
    chk("bnc_ready_pre", 16'(rdy8), 16'h1);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (k <= 8 || (k >= 10 && k <= 17))
        chk($sformatf("bnc_k%0d_kc", k), 16'(kc8), 16'(lfsr_m[0]));
      else if (k == 9)
        chk("bnc_k9_kc", 16'(kc8), 16'h1);
      else
        chk($sformatf("bnc_k%0d_kc", k), 16'(kc8), 16'h0);
      chk($sformatf("bnc_k%0d_done", k), 16'(done8), (k == 18) ? 16'h1 : 16'h0);
      chk($sformatf("bnc_k%0d_ready", k), 16'(rdy8), (k == 19) ? 16'h1 : 16'h0);
    end

    // Reset in the middle of a long hold
    do_reset();
    force_mask = 16'h0000;
    row_in     = 4'b1101;
    req_valid  = 1'b1;
    req_key    = 4'h5;
    req_hold   = 16'd100;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      chk($sformatf("mid_k%0d_kc", k), 16'(kc0), 16'h1);
      chk($sformatf("mid_k%0d_done", k), 16'(done0), 16'h0);
      if (k >= 2) chk($sformatf("mid_k%0d_col", k), 16'(col0), 16'hD);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_kc", 16'(kc0), 16'h0);
    chk("mid_rst_col", 16'(col0), 16'hF);
    chk("mid_rst_done", 16'(done0), 16'h0);
    chk("mid_rst_busy", 16'(busy0), 16'h0);
    rst        = 1'b0;
    force_mask = 16'h8001;
    row_in     = 4'b0000;
    @(negedge clk);
    chk("mid_post_col0", 16'(col0), 16'h6);
    chk("mid_post_col8", 16'(col8), 16'h6);
    chk("mid_post_ready", 16'(rdy0), 16'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mid_nodone_%0d", k), 16'(done0), 16'h0);
    end

    // Forced key and sequencer key identical: stays closed throughout
    do_reset();
    force_mask = 16'h0020;
    row_in     = 4'b1101;
    req_valid  = 1'b1;
    req_key    = 4'h5;
    req_hold   = 16'd2;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      chk($sformatf("ovl_k%0d_col", k), 16'(col0), 16'hD);
      chk($sformatf("ovl_k%0d_done", k), 16'(done0), (k == 3) ? 16'h1 : 16'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
